// File: rtl/reg32_load_sequencer.sv
// Sequences byte-wide memory reads into a 32-bit register (MSB-first assembly) and issues
// single-cycle CLEAR/INC/DEC commands. All outputs are registered.
module reg32_load_sequencer #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_cmd,
  input  logic [1:0]            i_len,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_read,
  input  logic                  i_mem_ready,
  input  logic [7:0]            i_mem_data,
  output logic                  o_reg_e,
  output logic [2:0]            o_reg_fun_sel,
  output logic [31:0]           o_reg_i,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_error
);

  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StWrite, StOp, StDone, StErr} state_e;

  state_e                r_state;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_mem_read;
  logic                  r_reg_e;
  logic [2:0]            r_reg_fun_sel;
  logic [31:0]           r_reg_i;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [2:0]            r_remain;
  logic                  r_first;
  logic [TW-1:0]         r_to_cnt;

  logic [TW-1:0]         w_to_inc;
  logic [2:0]            w_remain_dec;

  assign w_to_inc     = r_to_cnt + TW'(1);
  assign w_remain_dec = r_remain - 3'd1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state       <= StIdle;
      r_mem_addr    <= '0;
      r_mem_read    <= 1'b0;
      r_reg_e       <= 1'b0;
      r_reg_fun_sel <= 3'b000;
      r_reg_i       <= '0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_error       <= 1'b0;
      r_remain      <= '0;
      r_first       <= 1'b0;
      r_to_cnt      <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          if (i_start) begin
            r_busy <= 1'b1;
            case (i_cmd)
              3'b000: begin
                r_state    <= StFetch;
                r_mem_addr <= i_base_addr;
                r_mem_read <= 1'b1;
                r_remain   <= {1'b0, i_len} + 3'd1;
                r_first    <= 1'b1;
                r_to_cnt   <= '0;
              end
              3'b001: begin
                r_state       <= StOp;
                r_reg_e       <= 1'b1;
                r_reg_fun_sel <= 3'b011;
              end
              3'b010: begin
                r_state       <= StOp;
                r_reg_e       <= 1'b1;
                r_reg_fun_sel <= 3'b001;
              end
              3'b011: begin
                r_state       <= StOp;
                r_reg_e       <= 1'b1;
                r_reg_fun_sel <= 3'b000;
              end
              default: begin
                r_state <= StErr;
                r_error <= 1'b1;
              end
            endcase
          end
        end
        StFetch: begin
          if (i_mem_ready) begin
            // First byte loads low 8 bits and clears the rest; later bytes shift in.
            r_state       <= StWrite;
            r_mem_read    <= 1'b0;
            r_reg_e       <= 1'b1;
            r_reg_fun_sel <= r_first ? 3'b100 : 3'b110;
            r_reg_i       <= {24'b0, i_mem_data};
            r_to_cnt      <= '0;
          end else if ((TIMEOUT != 0) && (w_to_inc == TW'(TIMEOUT))) begin
            r_state    <= StErr;
            r_mem_read <= 1'b0;
            r_error    <= 1'b1;
            r_to_cnt   <= '0;
          end else begin
            r_to_cnt <= w_to_inc;
          end
        end
        StWrite: begin
          r_reg_e  <= 1'b0;
          r_first  <= 1'b0;
          r_remain <= w_remain_dec;
          if (w_remain_dec != 3'd0) begin
            r_state    <= StFetch;
            r_mem_addr <= r_mem_addr + ADDR_WIDTH'(1);
            r_mem_read <= 1'b1;
          end else begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StOp: begin
          r_state <= StDone;
          r_reg_e <= 1'b0;
          r_done  <= 1'b1;
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        StErr: begin
          r_state <= StIdle;
          r_error <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state    <= StIdle;
          r_mem_read <= 1'b0;
          r_reg_e    <= 1'b0;
          r_busy     <= 1'b0;
          r_done     <= 1'b0;
          r_error    <= 1'b0;
        end
      endcase
    end
  end

  assign o_mem_addr    = r_mem_addr;
  assign o_mem_read    = r_mem_read;
  assign o_reg_e       = r_reg_e;
  assign o_reg_fun_sel = r_reg_fun_sel;
  assign o_reg_i       = r_reg_i;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_error       = r_error;

endmodule

// File: doc/reg32_load_sequencer.md
Name: reg32_load_sequencer

Overview:
- Sequences loads into one Register32bit instance from a byte-wide memory port.
- Assembles 1-4 byte values into the register MSB-first:
  - first byte loaded with FunSel 100 (load low 8 bits, upper bits cleared);
  - each later byte loaded with FunSel 110 (shift left 8, insert byte).
- Also issues single-cycle CLEAR/INC/DEC commands to the register.
- Sits between the control unit (Start/Cmd) and the register + memory, with a memory-ready handshake and a timeout.

Parameters:
- ADDR_WIDTH, 16, width of memory byte address.
- TIMEOUT, 15, max FETCH cycles waiting for MemReady before abort; 0 disables the timeout.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  command strobe; sampled only in IDLE.
- Cmd  in  3  000 LOAD, 001 CLEAR, 010 INC, 011 DEC, 1xx reserved.
- Len  in  2  LOAD byte count minus 1 (00=1 … 11=4); sampled with Start.
- BaseAddr  in  ADDR_WIDTH  address of first byte; sampled with Start.
- MemAddr  out  ADDR_WIDTH  current byte address.
- MemRead  out  1  read request; held high until MemReady.
- MemReady  in  1  byte valid on MemData this cycle.
- MemData  in  8  read byte.
- RegE  out  1  register enable.
- RegFunSel  out  3  register function select.
- RegI  out  32  register data input.
- Busy  out  1  high in every non-IDLE state.
- Done  out  1  one-cycle pulse on successful completion.
- Error  out  1  one-cycle pulse on timeout or reserved Cmd.

Behaviour:
- Reset (async, Reset=0):
  - state IDLE.
  - MemAddr=0, MemRead=0, RegE=0, RegFunSel=000, RegI=0.
  - Busy=0, Done=0, Error=0, byte/timeout counters 0.
  - Takes effect immediately mid-operation; no further register writes; register contents untouched.
- All outputs are registered or decoded from registered state only. No combinational path from MemData/MemReady to Reg* outputs.
- States: IDLE, FETCH, WRITE, OP, DONE, ERR.
- IDLE:
  - Start=1 latches Cmd, Len, BaseAddr.
  - LOAD -> FETCH, with MemAddr=BaseAddr and remaining bytes=Len+1.
  - CLEAR/INC/DEC -> OP.
  - 1xx -> ERR.
  - Start while Busy=1 is ignored; it is not queued.
- FETCH:
  - MemRead=1, MemAddr stable.
  - If MemReady=1: latch MemData, clear timeout counter, go WRITE.
  - Else increment timeout counter. If TIMEOUT≠0 and the counter reaches TIMEOUT, go ERR.
- WRITE (exactly one cycle):
  - MemRead=0, RegE=1, RegI={24'b0, latched byte}.
  - RegFunSel=100 for the first byte, 110 for later bytes.
  - Then decrement remaining bytes. If nonzero: MemAddr+1 and go FETCH; else go DONE.
- OP (one cycle): RegE=1, RegFunSel = 011 (CLEAR), 001 (INC) or 000 (DEC). Then -> DONE.
- DONE (one cycle): Done=1, then IDLE.
- ERR (one cycle): Error=1, no register write, then IDLE. A partially assembled register value is left as-is.
- Timing:
  - LOAD of N bytes with MemReady answered in the first FETCH cycle: Busy high for 2N+1 cycles; Done in cycle 2N+1 after the Start edge.
  - CLEAR/INC/DEC: 2 cycles.
- MemAddr increments modulo 2^ADDR_WIDTH; wrap is legal, no error.
- MemReady outside FETCH is ignored.
- Done and Error are never high together.
- RegE is high only in WRITE/OP, and for at most one cycle per byte/op.

Test Plan:
- Reset mid-LOAD: assert Reset=0 during the second FETCH of a 4-byte LOAD -> all outputs 0 in the same cycle; after release, IDLE with no extra RegE pulse.
- LOAD of 4 bytes:
  - Stimulus: Len=11, BaseAddr=0x0100, memory bytes 0x12,0x34,0x56,0x78, MemReady immediate.
  - Required: RegFunSel sequence 100,110,110,110; MemAddr 0x0100..0x0103; register Q=0x12345678; Done at cycle 9; Busy 9 cycles.
- LOAD with stalls and wrap:
  - Stimulus: Len=01, BaseAddr=0xFFFF, MemReady delayed 3 cycles per byte.
  - Required: MemAddr 0xFFFF then 0x0000; MemRead held until MemReady; Q=0x0000AABB for bytes 0xAA,0xBB.
- Timeout:
  - Stimulus: TIMEOUT=15, MemReady never asserted.
  - Required: Error pulse after 15 FETCH cycles, no RegE pulse, Busy drops next cycle.
  - With TIMEOUT=0: still waiting after 100 cycles.
- Single ops: CLEAR, then INC ×3, then DEC -> Q=0x00000002; each op Busy=2 cycles with one RegE pulse.
- Reserved Cmd and busy Start:
  - Cmd=101 -> Error pulse, no RegE.
  - Start pulsed during a LOAD -> ignored; only one Done.
